unidade_controle: RTL and testbench

Multi-cycle control FSM of the 8-bit processor. It sequences fetch, decode, execute, memory and write-back, and drives every select and enable in the datapath. That includes the 2:1 8-bit write-back data mux select (SelDado: 0 = ULA result, 1 = memory byte) and the address mux select. It sits directly upstream of the 2:1 muxes and register enables, and consumes only the instruction opcode, the ULA Zero flag and the memory ready handshake.

---
 rtl/unidade_controle_pkg.sv | 56 +++++
 rtl/unidade_controle_decodifica_saidas.sv | 56 +++++
 rtl/unidade_controle.sv | 107 ++++++++++
 tb/tb_unidade_controle.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared types for the multi-cycle control unit of the 8-bit processor:
// opcodes, FSM state encodings, ULA operation codes and the control word.
package unidade_controle_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_MOV = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_LD  = 3'b101,
        OP_ST  = 3'b110,
        OP_JZ  = 3'b111
    } opcode_e;

    // Encoding 3'b111 is unused and recovers through INICIO.
    typedef enum logic [2:0] {
        S_INICIO     = 3'b000,
        S_BUSCA      = 3'b001,
        S_DECODIFICA = 3'b010,
        S_EXECUTA    = 3'b011,
        S_MEMORIA    = 3'b100,
        S_ESCRITA    = 3'b101,
        S_PARADO     = 3'b110
    } estado_e;

    typedef enum logic [1:0] {
        ULA_PASS = 2'b00,
        ULA_ADD  = 2'b01,
        ULA_SUB  = 2'b10
    } op_ula_e;

    // Moore control word. The *_em_* bits are not outputs themselves:
    // they say which handshake/flag gates the PC/IR load pulse.
    typedef struct packed {
        logic       ir_em_pronto;
        logic       pc_em_pronto;
        logic       pc_em_zero;
        logic       sel_pc;
        logic       sel_endereco;
        logic       mem_leitura;
        logic       mem_escrita;
        logic [1:0] op_ula;
        logic       sel_dado;
        logic       reg_escrita;
    } ctrl_t;

    function automatic logic usa_memoria(input opcode_e op);
        return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic eh_carga(input opcode_e op);
        return (op == OP_LDI) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/unidade_controle_decodifica_saidas.sv
// Combinational decoder: FSM state + registered opcode -> control word.
// Ports: estado_i (state), opcode_i (latched opcode), ctrl_o (control word).
module decodifica_saidas
    import unidade_controle_pkg::*;
(
    input  estado_e estado_i,
    input  opcode_e opcode_i,
    output ctrl_t   ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (estado_i)
            S_BUSCA: begin
                ctrl_o.mem_leitura  = 1'b1;
                ctrl_o.ir_em_pronto = 1'b1;
                ctrl_o.pc_em_pronto = 1'b1;
            end
            S_EXECUTA: begin
                case (opcode_i)
                    OP_ADD: ctrl_o.op_ula = ULA_ADD;
                    OP_SUB: ctrl_o.op_ula = ULA_SUB;
                    OP_JZ: begin
                        ctrl_o.sel_pc     = 1'b1;
                        ctrl_o.pc_em_zero = 1'b1;
                    end
                    default: ctrl_o.op_ula = ULA_PASS;
                endcase
            end
            S_MEMORIA: begin
                case (opcode_i)
                    // LDI reads the immediate at PC and steps past it.
                    OP_LDI: begin
                        ctrl_o.mem_leitura  = 1'b1;
                        ctrl_o.pc_em_pronto = 1'b1;
                    end
                    OP_LD: begin
                        ctrl_o.mem_leitura  = 1'b1;
                        ctrl_o.sel_endereco = 1'b1;
                    end
                    OP_ST: begin
                        ctrl_o.mem_escrita  = 1'b1;
                        ctrl_o.sel_endereco = 1'b1;
                    end
                    default: ctrl_o.mem_leitura = 1'b0;
                endcase
            end
            S_ESCRITA: begin
                ctrl_o.reg_escrita = 1'b1;
                ctrl_o.sel_dado    = eh_carga(opcode_i);
            end
            default: ctrl_o.reg_escrita = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// Inputs: Clock, Reset (async high), Opcode, Zero, MemPronto.
// Outputs: IR/PC/register enables, PC/address/data selects, memory
// requests, OpULA. Macro UNIDADE_CONTROLE_HALT_EN turns opcode 000 into
// HALT and adds the Parado output.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] Opcode,
    input  logic       Zero,
    input  logic       MemPronto,
    output logic       IREscrita,
    output logic       PCEscrita,
    output logic       SelPC,
    output logic       SelEndereco,
    output logic       MemLeitura,
    output logic       MemEscrita,
    output logic [1:0] OpULA,
    output logic       SelDado,
    output logic       RegEscrita
`ifdef UNIDADE_CONTROLE_HALT_EN
    ,
    output logic       Parado
`endif
);

    estado_e estado_q, estado_d;
    opcode_e opcode_q, opcode_d;
    opcode_e opcode_in;
    ctrl_t   ctrl;

    assign opcode_in = opcode_e'(Opcode);

    // Opcode is only guaranteed from DECODIFICA on; latch it there.
    assign opcode_d = (estado_q == S_DECODIFICA) ? opcode_in : opcode_q;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            S_INICIO: estado_d = S_BUSCA;
            S_BUSCA: begin
                if (MemPronto) estado_d = S_DECODIFICA;
            end
            S_DECODIFICA: begin
                if (opcode_in == OP_NOP) begin
`ifdef UNIDADE_CONTROLE_HALT_EN
                    estado_d = S_PARADO;
`else
                    estado_d = S_BUSCA;
`endif
                end else if (usa_memoria(opcode_in)) begin
                    estado_d = S_MEMORIA;
                end else begin
                    estado_d = S_EXECUTA;
                end
            end
            S_EXECUTA: begin
                estado_d = (opcode_q == OP_JZ) ? S_BUSCA : S_ESCRITA;
            end
            S_MEMORIA: begin
                if (MemPronto) begin
                    estado_d = (opcode_q == OP_ST) ? S_BUSCA : S_ESCRITA;
                end
            end
            S_ESCRITA: estado_d = S_BUSCA;
`ifdef UNIDADE_CONTROLE_HALT_EN
            S_PARADO: estado_d = S_PARADO;
`endif
            default: estado_d = S_INICIO;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_q <= S_INICIO;
            opcode_q <= OP_NOP;
        end else begin
            estado_q <= estado_d;
            opcode_q <= opcode_d;
        end
    end

    decodifica_saidas u_dec (
        .estado_i (estado_q),
        .opcode_i (opcode_q),
        .ctrl_o   (ctrl)
    );

    // Only these two pulses see MemPronto/Zero combinationally.
    assign IREscrita   = ctrl.ir_em_pronto & MemPronto;
    assign PCEscrita   = (ctrl.pc_em_pronto & MemPronto)
                       | (ctrl.pc_em_zero & Zero);
    assign SelPC       = ctrl.sel_pc;
    assign SelEndereco = ctrl.sel_endereco;
    assign MemLeitura  = ctrl.mem_leitura;
    assign MemEscrita  = ctrl.mem_escrita;
    assign OpULA       = ctrl.op_ula;
    assign SelDado     = ctrl.sel_dado;
    assign RegEscrita  = ctrl.reg_escrita;

`ifdef UNIDADE_CONTROLE_HALT_EN
    assign Parado = (estado_q == S_PARADO);
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: vector table plus
// hand-written stall/reset/halt sequences, scoreboard-compared.
module tb_unidade_controle;

    logic       Clock;
    logic       Reset;
    logic [2:0] Opcode;
    logic       Zero;
    logic       MemPronto;
    logic       IREscrita, PCEscrita, SelPC, SelEndereco;
    logic       MemLeitura, MemEscrita, SelDado, RegEscrita;
    logic [1:0] OpULA;
`ifdef UNIDADE_CONTROLE_HALT_EN
    logic       Parado;
`endif

    unidade_controle dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .MemPronto   (MemPronto),
        .IREscrita   (IREscrita),
        .PCEscrita   (PCEscrita),
        .SelPC       (SelPC),
        .SelEndereco (SelEndereco),
        .MemLeitura  (MemLeitura),
        .MemEscrita  (MemEscrita),
        .OpULA       (OpULA),
        .SelDado     (SelDado),
        .RegEscrita  (RegEscrita)
`ifdef UNIDADE_CONTROLE_HALT_EN
        ,
        .Parado      (Parado)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Output word: {IR,PC,SelPC,SelEnd,MemLe,MemEs,OpULA[1:0],SelDado,RegEs}
    localparam logic [9:0] V_ZERO  = 10'b0000000000;
    localparam logic [9:0] V_FETCH = 10'b1100100000;
    localparam logic [9:0] V_FWAIT = 10'b0000100000;
    localparam logic [9:0] V_ADD   = 10'b0000000100;
    localparam logic [9:0] V_SUB   = 10'b0000001000;
    localparam logic [9:0] V_JZ1   = 10'b0110000000;
    localparam logic [9:0] V_JZ0   = 10'b0010000000;
    localparam logic [9:0] V_LDI   = 10'b0100100000;
    localparam logic [9:0] V_LD    = 10'b0001100000;
    localparam logic [9:0] V_ST    = 10'b0001010000;
    localparam logic [9:0] V_WBALU = 10'b0000000001;
    localparam logic [9:0] V_WBMEM = 10'b0000000011;

    typedef struct {
        string      nm;
        logic [2:0] op;
        logic       z;
        logic       rdy;
        logic [9:0] e;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         tests  = 0;
    int         failed = 0;

    function automatic logic [9:0] outs();
        return {IREscrita, PCEscrita, SelPC, SelEndereco, MemLeitura,
                MemEscrita, OpULA, SelDado, RegEscrita};
    endfunction

    task automatic add(input string nm, input logic [2:0] op,
                       input logic z, input logic rdy,
                       input logic [9:0] e);
        vec_t v;
        v.nm = nm; v.op = op; v.z = z; v.rdy = rdy; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string nm);
        logic [9:0] got;
        logic [9:0] exp_v;
        got   = outs();
        exp_v = sb.pop_front();
        tests++;
        if (got !== exp_v) begin
            failed++;
            $display("FAIL %s: got %b want %b", nm, got, exp_v);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic e);
        tests++;
        if (got !== e) begin
            failed++;
            $display("FAIL %s: got %b want %b", nm, got, e);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check at negedge.
    task automatic step(input string nm, input logic [2:0] op,
                        input logic z, input logic rdy,
                        input logic [9:0] e);
        Opcode    = op;
        Zero      = z;
        MemPronto = rdy;
        sb.push_back(e);
        @(negedge Clock);
        cmp(nm);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Opcode = 3'b000; Zero = 1'b0; MemPronto = 1'b0;

        // ADD with Zero/MemPronto high throughout: both must be ignored.
        add("add_f",  3'b011, 1, 1, V_FETCH);
        add("add_d",  3'b011, 1, 1, V_ZERO);
        add("add_ex", 3'b011, 1, 1, V_ADD);
        add("add_wb", 3'b011, 1, 1, V_WBALU);
        add("sub_f",  3'b100, 0, 1, V_FETCH);
        add("sub_d",  3'b100, 0, 0, V_ZERO);
        add("sub_ex", 3'b100, 0, 0, V_SUB);
        add("sub_wb", 3'b100, 0, 0, V_WBALU);
        add("mov_f",  3'b010, 0, 1, V_FETCH);
        add("mov_d",  3'b010, 0, 1, V_ZERO);
        add("mov_ex", 3'b010, 0, 1, V_ZERO);
        add("mov_wb", 3'b010, 0, 1, V_WBALU);
        add("ldi_f",  3'b001, 0, 1, V_FETCH);
        add("ldi_d",  3'b001, 0, 1, V_ZERO);
        add("ldi_m",  3'b001, 0, 1, V_LDI);
        add("ldi_wb", 3'b001, 0, 1, V_WBMEM);
        add("st_f",   3'b110, 0, 1, V_FETCH);
        add("st_d",   3'b110, 0, 1, V_ZERO);
        add("st_m",   3'b110, 0, 1, V_ST);
        add("jz1_f",  3'b111, 1, 1, V_FETCH);
        add("jz1_d",  3'b111, 1, 1, V_ZERO);
        add("jz1_ex", 3'b111, 1, 1, V_JZ1);
        add("jz0_f",  3'b111, 0, 1, V_FETCH);
        add("jz0_d",  3'b111, 0, 1, V_ZERO);
        add("jz0_ex", 3'b111, 0, 1, V_JZ0);
`ifndef UNIDADE_CONTROLE_HALT_EN
        add("nop_f",  3'b000, 0, 1, V_FETCH);
        add("nop_d",  3'b000, 0, 1, V_ZERO);
`endif

        @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++) step("reset", 3'b011, 1, 1, V_ZERO);
        Reset = 1'b0;
        step("inicio", 3'b011, 0, 1, V_ZERO);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].nm, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].e);

        // Fetch wait, then LD stalled two cycles in MEMORIA.
        step("ld_fwait", 3'b101, 0, 0, V_FWAIT);
        step("ld_f",     3'b101, 0, 1, V_FETCH);
        step("ld_d",     3'b101, 0, 1, V_ZERO);
        step("ld_m0",    3'b101, 0, 0, V_LD);
        step("ld_m1",    3'b101, 0, 0, V_LD);
        step("ld_m2",    3'b101, 0, 1, V_LD);
        step("ld_wb",    3'b101, 0, 1, V_WBMEM);

        // ST stalled; Reset in the second wait cycle drops MemEscrita.
        step("st2_f",  3'b110, 0, 1, V_FETCH);
        step("st2_d",  3'b110, 0, 1, V_ZERO);
        step("st2_m0", 3'b110, 0, 0, V_ST);
        MemPronto = 1'b0;
        #1;
        sb.push_back(V_ST);
        cmp("st2_m1");
        Reset = 1'b1;
        #1;
        sb.push_back(V_ZERO);
        cmp("st2_rst_async");
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step("st2_inicio", 3'b011, 0, 1, V_ZERO);
        step("st2_refetch", 3'b011, 0, 1, V_FETCH);
        step("st2_d2",  3'b011, 0, 1, V_ZERO);
        step("st2_ex2", 3'b011, 0, 1, V_ADD);
        step("st2_wb2", 3'b011, 0, 1, V_WBALU);

`ifdef UNIDADE_CONTROLE_HALT_EN
        step("halt_f", 3'b000, 0, 1, V_FETCH);
        chk1("halt_d_parado", Parado, 1'b0);
        step("halt_d", 3'b000, 0, 1, V_ZERO);
        for (int i = 0; i < 20; i++) begin
            chk1("halt_parado", Parado, 1'b1);
            step("halt_hold", 3'b000, 0, 1, V_ZERO);
        end
        Reset = 1'b1;
        #1;
        chk1("halt_rst_parado", Parado, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        step("halt_inicio", 3'b010, 0, 1, V_ZERO);
        step("halt_refetch", 3'b010, 0, 1, V_FETCH);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
